serial_adder: RTL and testbench

Parametrised digit-serial adder/subtractor, the successor to the fixed 4-bit ripple full adder.
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles, trading latency for area.
- Operands enter and results leave through a valid/ready handshake.
- Used as a reusable arithmetic unit in the datapath labs.

---
 rtl/serial_adder_pkg.sv | 29 ++
 rtl/serial_adder_digit.sv | 33 +++
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_t   : FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   clog2     : ceiling log2 of a positive integer
//   ndigits   : number of DIGIT-wide slices in a WIDTH-bit operand
//   cnt_width : digit-counter width (at least one bit)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int ndigits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-wide ripple-carry full adder.
//   a_d, b_d : operand digits
//   ci       : carry in to bit 0
//   s_d      : digit sum
//   co       : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed-overflow detection)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             ci,
  output logic [DIGIT-1:0] s_d,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_d  = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s_d[i]  = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]  = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
  end

  assign co       = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock over
// WIDTH/DIGIT cycles, with valid/ready handshakes on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (a, b, cin, sub)
//   out_valid/out_ready  : result handshake (sum, cout, ovf)
//   sub=0 : sum = a + b + cin      sub=1 : sum = a - b (cin ignored)
//   cout  : carry out of MSB (for sub, 1 means no borrow)
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIGITS = ndigits(WIDTH, DIGIT);
  localparam int CW      = cnt_width(NDIGITS);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic             carry, cout_r;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] s_d;
  logic             co;
  logic             accept;
  logic             last_digit;

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb;
  logic ovf_r;
`else
  logic c_msb_unused;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_d      (a_sr[DIGIT-1:0]),
    .b_d      (b_sr[DIGIT-1:0]),
    .ci       (carry),
    .s_d      (s_d),
    .co       (co),
`ifdef SERIAL_ADDER_OVF_EN
    .c_msb_in (c_msb)
`else
    .c_msb_in (c_msb_unused)
`endif
  );

  assign accept     = (state == S_IDLE) && in_valid;
  assign last_digit = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_RUN;
      end
      S_RUN: begin
        if (last_digit) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: B is inverted at load, carry seeded with 1.
  // Each new digit enters at the top of sum_r so after NDIGITS shifts the
  // first digit has reached bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= CW'(NDIGITS - 1);
    end else if (state == S_RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      sum_r <= (sum_r >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));
      carry <= co;
      if (last_digit) begin
        cout_r <= co;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_r  <= co ^ c_msb;
`endif
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8/1, 16/4, 8/8)
// compared against an arithmetic reference model.
module tb_serial_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_in, b_in;
  logic        cin, sub, out_ready;
  logic        iv0, iv1, iv2;

  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
  logic [7:0]  s0, s2;
  logic [15:0] s1;
`ifdef SERIAL_ADDER_OVF_EN
  logic        of0, of1, of2;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of0)
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a_in), .b(b_in), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of1)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of2)
`endif
  );

  int          sel;
  logic        o_ir, o_ov, o_co, o_of;
  logic [15:0] o_sum;

  always_comb begin
    o_ir = ir0; o_ov = ov0; o_co = co0; o_sum = {8'h00, s0}; o_of = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    o_of = of0;
`endif
    if (sel == 1) begin
      o_ir = ir1; o_ov = ov1; o_co = co1; o_sum = s1;
`ifdef SERIAL_ADDER_OVF_EN
      o_of = of1;
`endif
    end else if (sel == 2) begin
      o_ir = ir2; o_ov = ov2; o_co = co2; o_sum = {8'h00, s2};
`ifdef SERIAL_ADDER_OVF_EN
      o_of = of2;
`endif
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic set_iv(input int s, input logic v);
    case (s)
      0: iv0 = v;
      1: iv1 = v;
      default: iv2 = v;
    endcase
  endtask

  // One transaction on instance s; hold = cycles out_ready stays low in DONE
  // while in_valid is pulsed (must not be accepted).
  task automatic op(input int s, input logic [15:0] av, input logic [15:0] bv,
                    input logic ci, input logic sb, input int hold, input string tag);
    int          w, nd, lat;
    logic [16:0] full;
    logic [15:0] mask, beff, exp_sum;
    logic        exp_cout, exp_ovf;
    w    = (s == 1) ? 16 : 8;
    nd   = (s == 0) ? 8 : (s == 1) ? 4 : 1;
    mask = (s == 1) ? 16'hFFFF : 16'h00FF;
    beff = sb ? (~bv & mask) : (bv & mask);
    full = 17'(av & mask) + 17'(beff) + 17'(sb ? 1'b1 : ci);
    exp_sum  = full[15:0] & mask;
    exp_cout = full[w];
    exp_ovf  = (av[w-1] == beff[w-1]) && (exp_sum[w-1] != av[w-1]);
    exp_ovf  = exp_ovf & 1'b1;

    sel = s;
    out_ready = (hold == 0);
    @(negedge clk);
    a_in = av; b_in = bv; cin = ci; sub = sb; set_iv(s, 1'b1);
    n_vec++;
    if (o_ir !== 1'b1) begin
      n_err++; $display("FAIL %s in_ready_idle got %b want 1", tag, o_ir);
    end
    @(posedge clk); #1;
    set_iv(s, 1'b0);
    a_in = 16'($urandom); b_in = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    @(negedge clk);
    n_vec++;
    if ({o_ir, o_ov} !== 2'b00) begin
      n_err++; $display("FAIL %s run_flags got %b want 00", tag, {o_ir, o_ov});
    end
    lat = 0;
    while (lat < 64) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (o_ov === 1'b1) break;
    end
    n_vec++;
    if (lat != nd) begin
      n_err++; $display("FAIL %s latency got %0d want %0d", tag, lat, nd);
    end
    n_vec++;
    if (o_sum !== exp_sum) begin
      n_err++; $display("FAIL %s sum got %h want %h", tag, o_sum, exp_sum);
    end
    n_vec++;
    if (o_co !== exp_cout) begin
      n_err++; $display("FAIL %s cout got %b want %b", tag, o_co, exp_cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_vec++;
    if (o_of !== exp_ovf) begin
      n_err++; $display("FAIL %s ovf got %b want %b", tag, o_of, exp_ovf);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      set_iv(s, 1'b1); a_in = 16'($urandom); b_in = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({o_ov, o_ir, o_sum, o_co} !== {1'b1, 1'b0, exp_sum, exp_cout}) begin
        n_err++;
        $display("FAIL %s done_hold got ov=%b ir=%b sum=%h cout=%b want ov=1 ir=0 sum=%h cout=%b",
                 tag, o_ov, o_ir, o_sum, o_co, exp_sum, exp_cout);
      end
    end
    set_iv(s, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({o_ov, o_ir, o_sum} !== {1'b0, 1'b1, exp_sum}) begin
      n_err++;
      $display("FAIL %s release got ov=%b ir=%b sum=%h want ov=0 ir=1 sum=%h",
               tag, o_ov, o_ir, o_sum, exp_sum);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv0 = 0; iv1 = 0; iv2 = 0; a_in = '0; b_in = '0;
    cin = 0; sub = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_vec++;
      if ({o_ir, o_ov, o_sum, o_co} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
        n_err++;
        $display("FAIL reset[%0d] got ir=%b ov=%b sum=%h cout=%b want ir=1 ov=0 sum=0000 cout=0",
                 s, o_ir, o_ov, o_sum, o_co);
      end
    end
  endtask

  task automatic test_basic();
    op(0, 16'h07, 16'h08, 1'b1, 1'b0, 0, "add_7_8");
    op(0, 16'hFF, 16'h05, 1'b1, 1'b0, 0, "add_ff_5");
    op(0, 16'h00, 16'h00, 1'b0, 1'b0, 0, "add_zero");
  endtask

  task automatic test_sub();
    op(0, 16'h05, 16'h07, 1'b1, 1'b1, 0, "sub_5_7");
    op(0, 16'h07, 16'h05, 1'b1, 1'b1, 0, "sub_7_5");
  endtask

  task automatic test_hold();
    op(0, 16'h3C, 16'h5A, 1'b0, 1'b0, 5, "hold");
  endtask

  task automatic test_reset_mid();
    logic seen;
    sel = 0;
    out_ready = 1'b1;
    @(negedge clk);
    a_in = 16'h12; b_in = 16'h34; cin = 0; sub = 0; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({o_ir, o_ov, o_sum, o_co} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid got ir=%b ov=%b sum=%h cout=%b want ir=1 ov=0 sum=0000 cout=0",
               o_ir, o_ov, o_sum, o_co);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_ov !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_pulse got out_valid pulse=%b want 0", seen);
    end
    out_ready = 1'b0;
    op(0, 16'h10, 16'h20, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_wide_digit();
    op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "w16_ovf");
    op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, "w16_sub_ovf");
    op(2, 16'hF0, 16'h20, 1'b1, 1'b0, 0, "w8d8_add");
    op(2, 16'h80, 16'h01, 1'b0, 1'b1, 2, "w8d8_sub");
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 15; n++) begin
        op(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 2)), "rand");
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 0, "b2b");
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_basic();
    test_sub();
    test_hold();
    test_reset_mid();
    test_wide_digit();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
